test_csr_mc: RTL and testbench

- Parametrised, multi-channel successor of the single-channel test CSR block. It sits on the register interface (reg_req_t/reg_rsp_t) as a test/debug peripheral.
- Provides NUM_CH independent read/write test channels. Each channel has address, write data, captured read data, one-cycle start pulses, a busy/done handshake with the channel target, a timeout counter, sticky status bits and a maskable interrupt.

---
 rtl/test_csr_mc.sv | 195 +++++++++++++++++++
 tb/tb_test_csr_mc.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_csr_mc.sv
// Multi-channel test/debug CSR peripheral: per-channel read/write start pulses,
// busy/done handshake with optional timeout, sticky status and a maskable irq.
module test_csr_mc #(
    parameter type reg_req_t = struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    },
    parameter type reg_rsp_t = struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    },
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  reg_req_t                       reg_req_i,
    output reg_rsp_t                       reg_rsp_o,
    output logic [NUM_CH-1:0][DATA_W-1:0]  ch_addr_o,
    output logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata_o,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_rdata_i,
    output logic [NUM_CH-1:0]              ch_start_read_o,
    output logic [NUM_CH-1:0]              ch_start_write_o,
    input  logic [NUM_CH-1:0]              ch_done_i,
    output logic                           irq_o
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic [NUM_CH-1:0]                state_q, state_d;
    logic [NUM_CH-1:0]                start_rd_q, start_rd_d, start_wr_q, start_wr_d;
    logic [NUM_CH-1:0]                last_rd_q, last_rd_d;
    logic [NUM_CH-1:0]                done_q, done_d, to_q, to_d, err_q, err_d;
    logic [NUM_CH-1:0]                irq_en_q, irq_en_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_CH-1:0][TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0]             timeout_q, timeout_d;
    logic                             irq_q, irq_d;

    logic [31:0]       off, ch_idx, wd, rdata;
    logic [4:0]        sub;
    logic              is_glb, is_ch, mapped, we;
    logic [NUM_CH-1:0] ch_we, pend;
    logic              unused_req;

    assign unused_req = ^{reg_req_i.wstrb, reg_req_i.addr};
    assign pend       = done_q | to_q | err_q;

    always_comb begin
        off    = 32'(reg_req_i.addr[ADDR_W-1:0]);
        ch_idx = (off - 32'h40) >> 5;
        sub    = off[4:0];
        is_glb = off < 32'h10;
        is_ch  = (off >= 32'h40) && (ch_idx < 32'(NUM_CH)) && (sub <= 5'h10);
        mapped = (off[1:0] == 2'b00) && (is_glb || is_ch);
        we     = reg_req_i.valid && reg_req_i.write && mapped;
        wd     = 32'(reg_req_i.wdata);
        for (int c = 0; c < NUM_CH; c++) begin
            ch_we[c] = we && is_ch && (ch_idx == 32'(c));
        end
    end

    always_comb begin
        rdata = '0;
        if (mapped && is_glb) begin
            case (off[3:2])
                2'd0:    rdata = {16'h7E57, 8'(DATA_W), 8'(NUM_CH)};
                2'd1:    rdata = 32'(irq_en_q);
                2'd2:    rdata = 32'(pend);
                default: rdata = 32'(timeout_q);
            endcase
        end else if (mapped) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 32'(c)) begin
                    case (sub)
                        5'h00:   rdata = 32'(addr_q[c]);
                        5'h04:   rdata = 32'(wdata_q[c]);
                        5'h08:   rdata = 32'(rdata_q[c]);
                        5'h10:   rdata = 32'({last_rd_q[c], err_q[c], to_q[c], done_q[c], state_q[c]});
                        default: rdata = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata;
        reg_rsp_o.error = reg_req_i.valid && !mapped;
        reg_rsp_o.ready = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        start_rd_d = '0;
        start_wr_d = '0;
        last_rd_d  = last_rd_q;
        done_d     = done_q;
        to_d       = to_q;
        err_d      = err_q;
        irq_en_d   = irq_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        if (we && is_glb && off[3:2] == 2'd1) irq_en_d  = wd[NUM_CH-1:0];
        if (we && is_glb && off[3:2] == 2'd3) timeout_d = wd[TIMEOUT_W-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
            // Clears are applied before hardware sets so a same-cycle set wins.
            if (ch_we[c] && sub == 5'h10) begin
                done_d[c] = done_q[c] & ~wd[1];
                to_d[c]   = to_q[c] & ~wd[2];
                err_d[c]  = err_q[c] & ~wd[3];
            end
            if (ch_we[c] && sub == 5'h00) addr_d[c]  = wd[DATA_W-1:0];
            if (ch_we[c] && sub == 5'h04) wdata_d[c] = wd[DATA_W-1:0];
            // The start-pulse cycle neither accepts done nor counts down.
            if (state_q[c] == ST_BUSY && !(start_rd_q[c] || start_wr_q[c])) begin
                if (ch_done_i[c]) begin
                    done_d[c]  = 1'b1;
                    state_d[c] = ST_IDLE;
                    if (last_rd_q[c]) rdata_d[c] = ch_rdata_i[c];
                end else if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - TIMEOUT_W'(1);
                    if (cnt_q[c] == TIMEOUT_W'(1)) begin
                        to_d[c]    = 1'b1;
                        state_d[c] = ST_IDLE;
                    end
                end
            end
            if (ch_we[c] && sub == 5'h0C) begin
                if (wd[1:0] == 2'b11 || (state_q[c] == ST_BUSY && wd[1:0] != 2'b00)) begin
                    err_d[c] = 1'b1;
                end else if (wd[1:0] != 2'b00) begin
                    state_d[c]    = ST_BUSY;
                    start_wr_d[c] = wd[0];
                    start_rd_d[c] = wd[1];
                    last_rd_d[c]  = wd[1];
                    cnt_d[c]      = timeout_q;
                end
            end
        end
        irq_d = |(pend & irq_en_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= '0;
            start_rd_q <= '0;
            start_wr_q <= '0;
            last_rd_q  <= '0;
            done_q     <= '0;
            to_q       <= '0;
            err_q      <= '0;
            irq_en_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_rd_q <= start_rd_d;
            start_wr_q <= start_wr_d;
            last_rd_q  <= last_rd_d;
            done_q     <= done_d;
            to_q       <= to_d;
            err_q      <= err_d;
            irq_en_q   <= irq_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            irq_q      <= irq_d;
        end
    end

    assign ch_addr_o        = addr_q;
    assign ch_wdata_o       = wdata_q;
    assign ch_start_read_o  = start_rd_q;
    assign ch_start_write_o = start_wr_q;
    assign irq_o            = irq_q;

endmodule

// File: tb/tb_test_csr_mc.sv
// Bench for test_csr_mc: directed scenarios plus random register traffic, checked
// against a timestamp-based reference model through response and pulse scoreboards.
module tb_test_csr_mc;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_t                          req;
    rsp_t                          rsp;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_addr, ch_wdata, ch_rdata;
    logic [NUM_CH-1:0]             start_rd, start_wr, ch_done;
    logic                          irq;

    test_csr_mc #(
        .reg_req_t (req_t),
        .reg_rsp_t (rsp_t),
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .ADDR_W    (8),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .reg_req_i        (req),
        .reg_rsp_o        (rsp),
        .ch_addr_o        (ch_addr),
        .ch_wdata_o       (ch_wdata),
        .ch_rdata_i       (ch_rdata),
        .ch_start_read_o  (start_rd),
        .ch_start_write_o (start_wr),
        .ch_done_i        (ch_done),
        .irq_o            (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input bit ok, input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    // Cycle n is the interval after the n-th rising edge. A channel started at the
    // edge ending cycle n pulses in cycle s=n+1 and, with timeout T, is busy up to cycle s+T.
    int          cyc = 0;
    logic [31:0] m_addr[NUM_CH], m_wdata[NUM_CH], m_rdata[NUM_CH];
    bit          m_busy[NUM_CH], m_last_rd[NUM_CH], m_done[NUM_CH], m_to[NUM_CH], m_err[NUM_CH];
    int          m_start[NUM_CH], m_tmo[NUM_CH];
    logic [31:0] m_irq_en, m_timeout;
    bit          m_irq;

    logic [33:0] exp_q[$];    // {is_read, error, rdata}
    logic [19:0] pulse_q[$];  // {cycle, channel, is_read}
    bit          mon_en = 1'b0;

    function automatic int decode(input logic [31:0] a, output int c, output int r);
        int o;
        o = int'(a[7:0]);
        c = 0;
        r = o;
        if (o % 4 != 0) return 0;
        if (o < 16) return 1;
        if (o >= 64) begin
            c = (o - 64) / 32;
            r = (o - 64) % 32;
            if (c < NUM_CH && r <= 16) return 2;
        end
        return 0;
    endfunction

    function automatic logic [NUM_CH-1:0] m_pend();
        logic [NUM_CH-1:0] p;
        for (int i = 0; i < NUM_CH; i++) p[i] = m_done[i] | m_to[i] | m_err[i];
        return p;
    endfunction

    function automatic void model_read(input logic [31:0] a, output bit e, output logic [31:0] d);
        int kind, c, r;
        kind = decode(a, c, r);
        e = (kind == 0);
        d = 32'h0;
        if (kind == 1) begin
            if (r == 0) d = 32'h7E572004;
            if (r == 4) d = m_irq_en;
            if (r == 8) d = 32'(m_pend());
            if (r == 12) d = m_timeout;
        end else if (kind == 2) begin
            if (r == 0) d = m_addr[c];
            if (r == 4) d = m_wdata[c];
            if (r == 8) d = m_rdata[c];
            if (r == 16) d = 32'({m_last_rd[c], m_err[c], m_to[c], m_done[c], m_busy[c]});
        end
    endfunction

    function automatic void model_edge();
        int          kind, c, r;
        bit          we, hit, busy0;
        logic [31:0] d;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_addr[i] = 0; m_wdata[i] = 0; m_rdata[i] = 0; m_busy[i] = 0; m_last_rd[i] = 0;
                m_done[i] = 0; m_to[i] = 0; m_err[i] = 0; m_start[i] = 0; m_tmo[i] = 0;
            end
            m_irq_en = 0;
            m_timeout = 0;
            m_irq = 0;
            pulse_q.delete();
            cyc++;
            return;
        end
        m_irq = (m_pend() & m_irq_en[NUM_CH-1:0]) != '0;
        we = req.valid && req.write;
        kind = decode(req.addr, c, r);
        d = req.wdata;
        if (we && kind == 1 && r == 4) m_irq_en = d & 32'hF;
        if (we && kind == 1 && r == 12) m_timeout = d & 32'hFFFF;
        for (int i = 0; i < NUM_CH; i++) begin
            hit = we && kind == 2 && c == i;
            busy0 = m_busy[i];
            if (hit && r == 16) begin
                if (d[1]) m_done[i] = 0;
                if (d[2]) m_to[i] = 0;
                if (d[3]) m_err[i] = 0;
            end
            if (hit && r == 0) m_addr[i] = d;
            if (hit && r == 4) m_wdata[i] = d;
            if (m_busy[i] && cyc > m_start[i]) begin
                if (ch_done[i]) begin
                    m_done[i] = 1;
                    m_busy[i] = 0;
                    if (m_last_rd[i]) m_rdata[i] = ch_rdata[i];
                end else if (m_tmo[i] != 0 && cyc == m_start[i] + m_tmo[i]) begin
                    m_to[i] = 1;
                    m_busy[i] = 0;
                end
            end
            if (hit && r == 12) begin
                if (d[1:0] == 2'b11 || (busy0 && d[1:0] != 2'b00)) begin
                    m_err[i] = 1;
                end else if (d[1:0] != 2'b00) begin
                    m_busy[i] = 1;
                    m_start[i] = cyc + 1;
                    m_tmo[i] = int'(m_timeout);
                    m_last_rd[i] = d[1];
                    pulse_q.push_back({16'(cyc + 1), 3'(i), d[1]});
                end
            end
        end
        cyc++;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input logic [33:0] e);
        req.addr  = a;
        req.write = w;
        req.wdata = d;
        req.wstrb = 4'($urandom);
        req.valid = 1'b1;
        exp_q.push_back(e);
        tick();
        req.valid = 1'b0;
        req.write = 1'b0;
        ch_done   = '0;
    endtask

    task automatic idle();
        tick();
        ch_done = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        bit e;
        logic [31:0] d;
        model_read(a, e, d);
        issue(a, 1'b0, 32'h0, {1'b1, e, d});
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] d, input bit e);
        issue(a, 1'b0, 32'h0, {1'b1, e, d});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit e;
        logic [31:0] unused_d;
        model_read(a, e, unused_d);
        issue(a, 1'b1, d, {1'b0, e, 32'h0});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [33:0]                   e;
        logic [19:0]                   seen, got;
        logic [NUM_CH-1:0][DATA_W-1:0] ea, ew;
        bit                            p;
        if (mon_en) begin
            if (req.valid) begin
                check(exp_q.size() > 0, "rsp_unexpected", 64'(rsp), 0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(rsp.error === e[32] && rsp.ready === 1'b1, "rsp_error",
                          {rsp.error, rsp.ready}, {e[32], 1'b1});
                    if (e[33]) check(rsp.rdata === e[31:0], "rsp_rdata", rsp.rdata, e[31:0]);
                end
            end
            check(irq === m_irq, "irq_level", irq, m_irq);
            for (int i = 0; i < NUM_CH; i++) begin
                ea[i] = m_addr[i];
                ew[i] = m_wdata[i];
            end
            check(ch_addr === ea && ch_wdata === ew, "ch_addr_wdata", ch_addr[0], ea[0]);
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 2; k++) begin
                    p = (k == 1) ? start_rd[c] : start_wr[c];
                    if (p) begin
                        seen = {16'(cyc), 3'(c), 1'(k)};
                        check(pulse_q.size() > 0, "pulse_unexpected", seen, 0);
                        if (pulse_q.size() > 0) begin
                            got = pulse_q.pop_front();
                            check(seen == got, "start_pulse", seen, got);
                        end
                    end
                end
            end
            while (pulse_q.size() > 0 && pulse_q[0][19:4] <= 16'(cyc)) begin
                check(1'b0, "pulse_missing", 0, pulse_q[0]);
                void'(pulse_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] a, d;
    int          kind, c;

    initial begin
        req      = '0;
        ch_done  = '0;
        ch_rdata = '0;
        rst      = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset values
        check(irq === 1'b0, "irq_reset", irq, 0);
        rd_exp(32'h00, 32'h7E572004, 1'b0);
        rd_exp(32'h50, 32'h0, 1'b0);

        // Channel 1 read path
        wr(32'h60, 32'h1234);
        wr(32'h04, 32'h2);
        wr(32'h6C, 32'h2);
        check(start_rd === 4'b0010 && start_wr === 4'b0, "ch1_start_read", start_rd, 4'b0010);
        rd_exp(32'h70, 32'h11, 1'b0);
        check(start_rd === 4'b0, "ch1_pulse_one_cycle", start_rd, 0);
        ch_rdata[1] = 32'hCAFEF00D;
        ch_done[1]  = 1'b1;
        rd_exp(32'h70, 32'h11, 1'b0);
        check(irq === 1'b0, "irq_not_yet", irq, 0);
        rd_exp(32'h68, 32'hCAFEF00D, 1'b0);
        check(irq === 1'b1, "irq_after_done", irq, 1);
        rd_exp(32'h70, 32'h12, 1'b0);
        wr(32'h70, 32'h2);
        rd_exp(32'h70, 32'h10, 1'b0);
        check(irq === 1'b0, "irq_cleared", irq, 0);

        // Misuse on channel 3
        wr(32'hAC, 32'h3);
        check({start_rd, start_wr} === 8'h0, "both_bits_no_pulse", {start_rd, start_wr}, 0);
        rd_exp(32'hB0, 32'h8, 1'b0);
        wr(32'hB0, 32'h8);
        wr(32'hAC, 32'h1);
        check(start_wr === 4'b1000, "ch3_start_write", start_wr, 4'b1000);
        wr(32'hAC, 32'h1);
        check({start_rd, start_wr} === 8'h0, "busy_no_second_pulse", {start_rd, start_wr}, 0);
        rd_exp(32'hB0, 32'h9, 1'b0);
        ch_done[3] = 1'b1;
        idle();
        rd_exp(32'hB0, 32'hA, 1'b0);
        wr(32'hB0, 32'hA);

        // Timeout on channel 0, then done in the expiry cycle
        wr(32'h0C, 32'h5);
        wr(32'h4C, 32'h1);
        repeat (6) rd_exp(32'h50, 32'h1, 1'b0);
        rd_exp(32'h50, 32'h4, 1'b0);
        wr(32'h50, 32'h4);
        wr(32'h4C, 32'h1);
        repeat (5) rd_exp(32'h50, 32'h1, 1'b0);
        ch_done[0] = 1'b1;
        rd_exp(32'h50, 32'h1, 1'b0);
        rd_exp(32'h50, 32'h2, 1'b0);
        wr(32'h50, 32'h2);

        // Error responses
        rd_exp(32'h20, 32'h0, 1'b1);
        rd_exp(32'h42, 32'h0, 1'b1);
        wr(32'h20, 32'hFFFF_FFFF);
        rd_exp(32'h04, 32'h2, 1'b0);
        rd_exp(32'h0C, 32'h5, 1'b0);

        // Reset while channel 2 is busy with irq asserted
        wr(32'h0C, 32'h0);
        wr(32'h80, 32'hABCD);
        wr(32'h04, 32'hF);
        wr(32'hAC, 32'h3);
        wr(32'h8C, 32'h2);
        idle();
        idle();
        check(irq === 1'b1, "irq_before_reset", irq, 1);
        rd_exp(32'h90, 32'h11, 1'b0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check({start_rd, start_wr} === 8'h0, "reset_pulses", {start_rd, start_wr}, 0);
        check(irq === 1'b0, "reset_irq", irq, 0);
        check(ch_addr === '0, "reset_ch_addr", ch_addr[2], 0);
        rd_exp(32'h90, 32'h0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_rdata[k] = $urandom;
                ch_done[k]  = ($urandom_range(0, 7) == 0);
            end
            kind = $urandom_range(0, 9);
            c = $urandom_range(0, NUM_CH - 1);
            if (kind == 0) a = 32'($urandom_range(0, 255));
            else if (kind == 1) a = 32'($urandom_range(0, 3) * 4);
            else a = 32'(64 + 32 * c + 4 * $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FF00);
            d = $urandom;
            if (a[7:0] == 8'h0C) d = 32'($urandom_range(0, 6));
            else if (a[7:0] >= 8'h40 && a[4:0] == 5'h0C) d = 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       idle();
                1, 2, 3, 4: rd(a);
                default: wr(a, d);
            endcase
        end
        idle();
        idle();

        check(exp_q.size() == 0, "rsp_queue_drained", exp_q.size(), 0);
        check(pulse_q.size() == 0, "pulse_queue_drained", pulse_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
